// File: rtl/dma_axi_wr_drain_if.sv
// AXI4 write-address, write-data and write-response channels used by the DMA write drain.
interface dma_axi_wr_drain_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/dma_axi_wr_drain.sv
// DMA write drain: pops FIFO beats and writes them as AXI4 INCR bursts that never
// cross 4 KB, issuing each burst only once the FIFO already holds all of its beats.
module dma_axi_wr_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        dst_addr,
  input  logic [LEN_WIDTH-1:0]         num_beats,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  input  logic                         fifo_empty,
  input  logic [$clog2(FIFO_DEPTH):0]  fifo_ocup_cnt,
  dma_axi_wr_drain_if.master           axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW_WAIT, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [8:0]            blen_q;
  logic [8:0]            beat_cnt;
  logic                  err_sticky;
  logic                  awvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  bready_q;

  logic in_w, wvalid, w_hs, last_beat, rem_last;

  // Burst length: smallest of remaining beats, MAX_BURST and the beats left before the 4 KB page ends.
  function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0] room;
    logic [31:0] b;
    room = (13'd4096 - {1'b0, a[11:0]}) >> SZ;
    b    = MAX_BURST;
    if (32'(room) < b) b = 32'(room);
    if (32'(rem) < b)  b = 32'(rem);
    return b[8:0];
  endfunction

  assign in_w       = (state == S_W);
  assign wvalid     = in_w & ~fifo_empty;
  assign w_hs       = wvalid & axi.wready;
  assign last_beat  = (beat_cnt == blen_q - 9'd1);
  assign rem_last   = (rem_q == LEN_WIDTH'(blen_q));

  assign fifo_rd_en  = w_hs;
  assign axi.wvalid  = wvalid;
  assign axi.wdata   = in_w ? fifo_dout : '0;
  assign axi.wstrb   = '1;
  assign axi.wlast   = in_w & last_beat;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = 3'(SZ);
  assign axi.awburst = 2'b01;
  assign axi.bready  = bready_q;

  // Command address/length tracking (data only, no reset needed).
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) begin
        addr_q <= dst_addr & ALIGN_MASK;
        rem_q  <= num_beats;
      end
      S_CALC: blen_q <= burst_len(addr_q, rem_q);
      S_B: if (axi.bvalid && !axi.bresp[1]) begin
        addr_q <= addr_q + (ADDR_WIDTH'(blen_q) << SZ);
        rem_q  <= rem_q - LEN_WIDTH'(blen_q);
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      bready_q   <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          if (num_beats == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: state <= S_AW_WAIT;
        S_AW_WAIT: if (32'(fifo_ocup_cnt) >= 32'(blen_q)) begin
          awvalid_q <= 1'b1;
          awaddr_q  <= addr_q;
          awlen_q   <= 8'(blen_q - 9'd1);
          beat_cnt  <= '0;
          state     <= S_AW;
        end
        S_AW: if (axi.awready) begin
          awvalid_q <= 1'b0;
          state     <= S_W;
        end
        S_W: if (w_hs) begin
          if (last_beat) begin
            bready_q <= 1'b1;
            state    <= S_B;
          end else begin
            beat_cnt <= beat_cnt + 9'd1;
          end
        end
        S_B: if (axi.bvalid) begin
          bready_q <= 1'b0;
          // SLVERR/DECERR aborts the rest of the command.
          if (axi.bresp[1]) begin
            err_sticky <= 1'b1;
            done       <= 1'b1;
            err        <= 1'b1;
            state      <= S_DONE;
          end else if (rem_last) begin
            done  <= 1'b1;
            err   <= err_sticky;
            state <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_DONE: begin
          done       <= 1'b0;
          err        <= 1'b0;
          busy       <= 1'b0;
          err_sticky <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_wr_drain.sv
// Directed bench for dma_axi_wr_drain: table of transfer commands with expected bursts,
// plus hand-written zero-length and mid-burst reset sequences.
module tb_dma_axi_wr_drain;
  localparam int DW = 64;
  localparam int AWD = 32;
  localparam int FD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [AWD-1:0]  dst_addr;
  logic [15:0]     num_beats;
  logic            busy, done, err, fifo_rd_en;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_empty;
  logic [4:0]      fifo_ocup_cnt;

  dma_axi_wr_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) axi ();

  dma_axi_wr_drain #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .FIFO_DEPTH(FD), .MAX_BURST(16), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dst_addr(dst_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err(err), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_ocup_cnt(fifo_ocup_cnt), .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      nbeats;
    logic [7:0]       preload;
    logic [7:0]       feed_hold;
    logic [7:0]       aw_delay;
    logic             wtoggle;
    logic [3:0]       err_burst;
    logic [3:0]       exp_n;
    logic [2:0][31:0] exp_addr;
    logic [2:0][7:0]  exp_len;
    logic             exp_err;
  } vec_t;

  vec_t vecs [9];
  int npass = 0;
  int ntotal = 0;
  logic [DW-1:0] fq [$];

  int r_naw, r_done, r_beats, r_data, r_last, r_stab, r_ord, r_starve, r_timeout, r_fifo_left;
  logic r_err;
  logic [31:0] r_addr [3];
  logic [7:0]  r_len [3];

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] n, input int pre,
                              input int hold, input int awd, input logic tog, input int eb,
                              input int en, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input int l0, input int l1, input int l2,
                              input logic ee);
    vec_t v;
    v.addr = a; v.nbeats = n; v.preload = 8'(pre); v.feed_hold = 8'(hold);
    v.aw_delay = 8'(awd); v.wtoggle = tog; v.err_burst = 4'(eb); v.exp_n = 4'(en);
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
    v.exp_len[0] = 8'(l0); v.exp_len[1] = 8'(l1); v.exp_len[2] = 8'(l2);
    v.exp_err = ee;
    return v;
  endfunction

  function automatic logic [DW-1:0] word(input int vid, input int i);
    return {16'hA5C3, 16'(vid), 32'(i)};
  endfunction

  function automatic void fifo_sync();
    fifo_dout     = (fq.size() > 0) ? fq[0] : '0;
    fifo_empty    = (fq.size() == 0);
    fifo_ocup_cnt = 5'(fq.size());
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
    chk({tag, " err"}, 64'(err), 0);
    chk({tag, " awvalid"}, 64'(axi.awvalid), 0);
    chk({tag, " wvalid"}, 64'(axi.wvalid), 0);
    chk({tag, " wlast"}, 64'(axi.wlast), 0);
    chk({tag, " bready"}, 64'(axi.bready), 0);
    chk({tag, " fifo_rd_en"}, 64'(fifo_rd_en), 0);
    chk({tag, " awaddr"}, 64'(axi.awaddr), 0);
    chk({tag, " awlen"}, 64'(axi.awlen), 0);
    chk({tag, " wdata"}, 64'(axi.wdata), 0);
    chk({tag, " awsize"}, 64'(axi.awsize), 3);
    chk({tag, " awburst"}, 64'(axi.awburst), 1);
  endtask

  task automatic run_cmd(input int vid, input vec_t v);
    int cyc, tail, pushed, exp_idx, w_left, b_cnt, aw_low;
    logic aw_pend, s_aw_hs, s_w_hs, s_b_hs, s_rd, s_last_beat;
    logic [31:0] h_addr;
    logic [7:0]  h_len;
    bit fin;
    fq.delete();
    pushed = 0;
    for (int i = 0; i < int'(v.preload); i++) begin fq.push_back(word(vid, pushed)); pushed++; end
    fifo_sync();
    r_naw = 0; r_done = 0; r_beats = 0; r_data = 0; r_last = 0; r_stab = 0; r_ord = 0;
    r_starve = 0; r_timeout = 0; r_err = 1'b0;
    for (int k = 0; k < 3; k++) begin r_addr[k] = '0; r_len[k] = '0; end
    cyc = 0; tail = 0; fin = 0; exp_idx = 0; w_left = 0; b_cnt = 0; aw_low = 0; aw_pend = 0;
    h_addr = '0; h_len = '0;
    axi.awready = (v.aw_delay == 0);
    axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    dst_addr = v.addr; num_beats = v.nbeats; start = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      s_aw_hs = axi.awvalid & axi.awready;
      s_w_hs = axi.wvalid & axi.wready;
      s_b_hs = axi.bvalid & axi.bready;
      s_rd = fifo_rd_en;
      s_last_beat = 1'b0;
      if (s_rd != s_w_hs) r_ord++;
      if (axi.awvalid) begin
        if (aw_pend) begin
          if (axi.awaddr != h_addr || axi.awlen != h_len) r_stab++;
        end else begin
          if (r_naw < 3) begin r_addr[r_naw] = axi.awaddr; r_len[r_naw] = axi.awlen; end
          r_naw++;
          if (int'(fifo_ocup_cnt) < int'(axi.awlen) + 1) r_starve++;
          if (w_left != 0 || axi.bvalid) r_ord++;
          h_addr = axi.awaddr; h_len = axi.awlen;
        end
        aw_pend = !s_aw_hs;
        if (!axi.awready) aw_low++;
      end else begin
        aw_pend = 1'b0;
      end
      if (s_w_hs) begin
        if (w_left == 0) r_ord++;
        else begin
          if (axi.wdata != word(vid, exp_idx)) r_data++;
          if (axi.wlast != (w_left == 1)) r_last++;
          exp_idx++; r_beats++; w_left--;
          if (w_left == 0) s_last_beat = 1'b1;
        end
      end
      if (s_aw_hs) w_left = int'(axi.awlen) + 1;
      if (done) begin r_done++; r_err = err; end
      if (r_done > 0) begin tail++; if (tail > 3) fin = 1; end
      @(posedge clk); #1;
      start = 1'b0;
      if (s_rd && fq.size() > 0) void'(fq.pop_front());
      if (cyc >= int'(v.feed_hold) && fq.size() < FD && pushed < int'(v.nbeats)) begin
        fq.push_back(word(vid, pushed)); pushed++;
      end
      if (s_aw_hs) aw_low = 0;
      axi.awready = (aw_low >= int'(v.aw_delay));
      axi.wready = v.wtoggle ? ~axi.wready : 1'b1;
      if (s_b_hs) begin axi.bvalid = 1'b0; b_cnt++; end
      if (s_last_beat) begin
        axi.bvalid = 1'b1;
        axi.bresp = (b_cnt == int'(v.err_burst)) ? 2'b10 : 2'b00;
      end
      fifo_sync();
      cyc++;
    end
    if (!fin) r_timeout = 1;
    r_fifo_left = fq.size();
    axi.bvalid = 1'b0;
  endtask

  task automatic check_vec(input int vid, input vec_t v);
    int exp_beats;
    string p;
    p = $sformatf("v%0d", vid);
    exp_beats = 0;
    chk({p, " timeout"}, 64'(r_timeout), 0);
    chk({p, " aw count"}, 64'(r_naw), 64'(v.exp_n));
    for (int k = 0; k < int'(v.exp_n); k++) begin
      chk($sformatf("%s awaddr[%0d]", p, k), 64'(r_addr[k]), 64'(v.exp_addr[k]));
      chk($sformatf("%s awlen[%0d]", p, k), 64'(r_len[k]), 64'(v.exp_len[k]));
      exp_beats += int'(v.exp_len[k]) + 1;
    end
    chk({p, " done pulses"}, 64'(r_done), 1);
    chk({p, " err"}, 64'(r_err), 64'(v.exp_err));
    chk({p, " beats"}, 64'(r_beats), 64'(exp_beats));
    chk({p, " wdata order errs"}, 64'(r_data), 0);
    chk({p, " wlast errs"}, 64'(r_last), 0);
    chk({p, " aw stability errs"}, 64'(r_stab), 0);
    chk({p, " ordering errs"}, 64'(r_ord), 0);
    chk({p, " aw before fifo full errs"}, 64'(r_starve), 0);
    if (!v.exp_err) chk({p, " fifo left"}, 64'(r_fifo_left), 0);
  endtask

  initial begin
    int dn, dcyc, act, zerr, seen;
    logic rd;
    vecs[0] = mk(32'h1000, 8,  8, 0, 0, 1'b0, 15, 1, 32'h1000, 0, 0, 7, 0, 0, 1'b0);
    vecs[1] = mk(32'h2000, 40, 0, 0, 0, 1'b0, 15, 3, 32'h2000, 32'h2080, 32'h2100, 15, 15, 7, 1'b0);
    vecs[2] = mk(32'h0FC0, 16, 0, 0, 0, 1'b0, 15, 2, 32'h0FC0, 32'h1000, 0, 7, 7, 0, 1'b0);
    vecs[3] = mk(32'h3000, 16, 5, 20, 10, 1'b1, 15, 1, 32'h3000, 0, 0, 15, 0, 0, 1'b0);
    vecs[4] = mk(32'h4000, 32, 0, 0, 0, 1'b0, 0, 1, 32'h4000, 0, 0, 15, 0, 0, 1'b1);
    vecs[5] = mk(32'h5000, 4,  0, 0, 0, 1'b0, 15, 1, 32'h5000, 0, 0, 3, 0, 0, 1'b0);
    vecs[6] = mk(32'h6007, 3,  0, 0, 0, 1'b0, 15, 1, 32'h6000, 0, 0, 2, 0, 0, 1'b0);
    vecs[7] = mk(32'h1FF8, 5,  0, 0, 0, 1'b0, 15, 2, 32'h1FF8, 32'h2000, 0, 0, 3, 0, 1'b0);
    vecs[8] = mk(32'h8000, 10, 0, 0, 0, 1'b0, 15, 1, 32'h8000, 0, 0, 9, 0, 0, 1'b0);

    rst_n = 1'b0; start = 1'b0; dst_addr = '0; num_beats = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    fq.delete(); fifo_sync();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(i, vecs[i]);
      check_vec(i, vecs[i]);
    end

    // Zero-length command: completion with no bus activity.
    fq.delete(); fifo_sync();
    dst_addr = 32'h9000; num_beats = '0; start = 1'b1;
    dn = 0; dcyc = -1; act = 0; zerr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin dn++; if (dcyc < 0) dcyc = i; if (err) zerr++; end
      if (axi.awvalid | axi.wvalid | axi.bready | fifo_rd_en) act++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("zero done pulses", 64'(dn), 1);
    chk("zero done latency ok", 64'(dcyc >= 1 && dcyc <= 2), 1);
    chk("zero axi activity", 64'(act), 0);
    chk("zero err", 64'(zerr), 0);
    chk("zero busy after", 64'(busy), 0);

    // Reset asserted in the middle of the W phase.
    fq.delete();
    for (int i = 0; i < 16; i++) fq.push_back(word(20, i));
    fifo_sync();
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
    dst_addr = 32'h7000; num_beats = 16'd16; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 3; i++) begin
      @(negedge clk);
      if (axi.wvalid & axi.wready) seen++;
      rd = fifo_rd_en;
      @(posedge clk); #1;
      start = 1'b0;
      if (rd && fq.size() > 0) void'(fq.pop_front());
      fifo_sync();
    end
    chk("midw beats before reset", 64'(seen), 3);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midw");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fq.delete(); fifo_sync();
    @(posedge clk); #1;
    run_cmd(8, vecs[8]);
    check_vec(8, vecs[8]);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
